// File: rtl/pconv_unit_pkg.sv
// rtl/pconv_unit_pkg.sv - shared widths and saturation helper for the pointwise conv unit
package pconv_unit_pkg;

  localparam int ACC_W   = 32;
  localparam int BIAS_W  = 32;
  localparam int SHIFT_W = 5;

  function automatic logic signed [ACC_W-1:0] sat_n(input logic signed [ACC_W-1:0] v,
                                                      input int n);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = (32'sd1 <<< (n - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pconv_unit_if.sv
// rtl/pconv_unit_if.sv - pixel/parameter input bus and result output of one conv channel
interface pconv_unit_if #(
  parameter int N             = 16,
  parameter int INPUT_CHANNEL = 3
);
  import pconv_unit_pkg::*;

  logic                       input_vld;
  logic [INPUT_CHANNEL*N-1:0] input_din;
  logic [INPUT_CHANNEL*N-1:0] weight_din;
  logic [BIAS_W-1:0]          bias_din;
  logic [SHIFT_W-1:0]         shift_din;
  logic [N-1:0]               conv_dout;
  logic                       conv_dout_vld;

  modport master (
    output input_vld, input_din, weight_din, bias_din, shift_din,
    input  conv_dout, conv_dout_vld
  );

  modport slave (
    input  input_vld, input_din, weight_din, bias_din, shift_din,
    output conv_dout, conv_dout_vld
  );

endinterface

// File: rtl/pconv_unit_sat.sv
// rtl/pconv_unit_sat.sv - arithmetic right shift (floor) then clamp to N-bit signed range
module pconv_sat
  import pconv_unit_pkg::*;
#(
  parameter int N = 16
) (
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  output logic signed [N-1:0]       dout_o
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_i >>> shift_i;
    dout_o  = N'(sat_n(shifted, N));
  end

endmodule

// File: rtl/pconv_unit.sv
// rtl/pconv_unit.sv - one output channel of a 1x1 quantized convolution
// capture -> products -> tree sum + bias -> shift/saturate; fixed latency for all copies
module pconv_unit
  import pconv_unit_pkg::*;
#(
  parameter int N             = 16,
  parameter int INPUT_CHANNEL = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  pconv_unit_if.slave    bus
);

  localparam int DEPTH  = $clog2(INPUT_CHANNEL);
  localparam int LEAVES = 1 << DEPTH;

  // capture stage: holds the pixel and its parameters from the accepting edge
  logic                       s0_vld_q;
  logic [INPUT_CHANNEL*N-1:0] s0_in_q;
  logic [INPUT_CHANNEL*N-1:0] s0_w_q;
  logic signed [BIAS_W-1:0]   s0_bias_q;
  logic [SHIFT_W-1:0]         s0_shift_q;

  logic                       s1_vld_q;
  logic signed [2*N-1:0]      s1_prod_q [INPUT_CHANNEL];
  logic signed [BIAS_W-1:0]   s1_bias_q;
  logic [SHIFT_W-1:0]         s1_shift_q;

  logic                       s2_vld_q;
  logic signed [ACC_W-1:0]    s2_acc_q;
  logic [SHIFT_W-1:0]         s2_shift_q;

  logic                       s3_vld_q;
  logic signed [N-1:0]        conv_dout_q;
  logic signed [N-1:0]        conv_dout_d;
  logic signed [N-1:0]        sat_dout;

  // pairwise adder tree over a power-of-two padded leaf set
  for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
    localparam int W = LEAVES >> l;
    logic [W-1:0][ACC_W-1:0] sum;
    for (genvar i = 0; i < W; i++) begin : g_node
      if (l == 0) begin : g_leaf
        if (i < INPUT_CHANNEL) begin : g_used
          assign sum[i] = ACC_W'(s1_prod_q[i]);
        end else begin : g_pad
          assign sum[i] = '0;
        end
      end else begin : g_add
        assign sum[i] = g_lvl[l-1].sum[2*i] + g_lvl[l-1].sum[2*i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.input_vld) begin
      s0_in_q    <= bus.input_din;
      s0_w_q     <= bus.weight_din;
      s0_bias_q  <= bus.bias_din;
      s0_shift_q <= bus.shift_din;
    end
    for (int c = 0; c < INPUT_CHANNEL; c++) begin
      s1_prod_q[c] <= $signed(s0_in_q[c*N +: N]) * $signed(s0_w_q[c*N +: N]);
    end
    s1_bias_q  <= s0_bias_q;
    s1_shift_q <= s0_shift_q;
    s2_acc_q   <= g_lvl[DEPTH].sum[0] + s1_bias_q;
    s2_shift_q <= s1_shift_q;
  end

  pconv_sat #(.N(N)) u_sat (
    .acc_i   (s2_acc_q),
    .shift_i (s2_shift_q),
    .dout_o  (sat_dout)
  );

  always_comb begin
    conv_dout_d = conv_dout_q;
    if (s2_vld_q) conv_dout_d = sat_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_vld_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      conv_dout_q <= '0;
    end else begin
      s0_vld_q    <= bus.input_vld;
      s1_vld_q    <= s0_vld_q;
      s2_vld_q    <= s1_vld_q;
      s3_vld_q    <= s2_vld_q;
      conv_dout_q <= conv_dout_d;
    end
  end

  assign bus.conv_dout     = conv_dout_q;
  assign bus.conv_dout_vld = s3_vld_q;

endmodule

// File: tb/tb_pconv_unit.sv
// tb/tb_pconv_unit.sv - directed and randomized bench for pconv_unit against an arithmetic model
module tb_pconv_unit;

  localparam int N  = 16;
  localparam int IC = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_s;

  always #5 clk = ~clk;

  pconv_unit_if #(.N(N), .INPUT_CHANNEL(IC)) bus ();

  pconv_unit #(.N(N), .INPUT_CHANNEL(IC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int last_exp = 0;
  int exp_map [int];

  task automatic check_eq(input string tag, input logic signed [31:0] act,
                          input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic int ref_conv(input int a[3], input int w[3], input int bias, input int sh);
    int acc;
    acc = 0;
    for (int c = 0; c < 3; c++) acc += a[c] * w[c];
    acc += bias;
    acc = acc >>> sh;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] r;
    case ($urandom_range(5))
      0:       r = 16'sh8000;
      1:       r = 16'sh7fff;
      2, 3:    r = 16'(int'($urandom_range(40)) - 20);
      default: r = 16'($urandom);
    endcase
    return int'(r);
  endfunction

  // pixel driven after edge cyc is accepted at edge cyc+1 and appears after edge cyc+4
  task automatic drive(input bit v, input bit rn, input int a[3], input int w[3],
                       input int bias, input int sh);
    @(negedge clk);
    rst_n          = rn;
    bus.input_vld  = v;
    bus.input_din  = {a[2][15:0], a[1][15:0], a[0][15:0]};
    bus.weight_din = {w[2][15:0], w[1][15:0], w[0][15:0]};
    bus.bias_din   = bias;
    bus.shift_din  = 5'(sh);
    if (v && rn) exp_map[cyc + 4] = ref_conv(a, w, bias, sh);
  endtask

  task automatic idle(input int n, input bit rn);
    int a[3];
    int w[3];
    repeat (n) begin
      for (int c = 0; c < 3; c++) begin
        a[c] = rnd16();
        w[c] = rnd16();
      end
      drive(1'b0, rn, a, w, int'($urandom), int'($urandom_range(31)));
    end
  endtask

  always @(posedge clk) begin
    rst_s = rst_n;
    cyc   = cyc + 1;
    #1;
    if (!rst_s) begin
      exp_map.delete();
      last_exp = 0;
      check_eq("rst_vld", bus.conv_dout_vld, 0);
      check_eq("rst_dout", $signed(bus.conv_dout), 0);
    end else begin
      if (exp_map.exists(cyc)) begin
        check_eq("vld", bus.conv_dout_vld, 1);
        last_exp = exp_map[cyc];
        exp_map.delete(cyc);
      end else begin
        check_eq("vld", bus.conv_dout_vld, 0);
      end
      check_eq("dout", $signed(bus.conv_dout), last_exp);
    end
  end

  initial begin
    int a[3];
    int w[3];
    int bias;
    int sh;
    int leftover;

    // reset held with live random traffic on the inputs
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) begin
        a[c] = rnd16();
        w[c] = rnd16();
      end
      drive(1'b1, 1'b0, a, w, int'($urandom), int'($urandom_range(31)));
    end

    a = '{1, 2, 3};    w = '{4, 5, 6};  drive(1'b1, 1'b1, a, w, 0, 0);   idle(5, 1'b1);
    a = '{-2, 3, 0};   w = '{5, 1, 7};  drive(1'b1, 1'b1, a, w, 10, 1);  idle(5, 1'b1);
    a = '{-3, 0, 0};   w = '{1, 0, 0};  drive(1'b1, 1'b1, a, w, 0, 1);   idle(5, 1'b1);
    a = '{300, 0, 0};  w = '{300, 0, 0}; drive(1'b1, 1'b1, a, w, 0, 0);  idle(5, 1'b1);
    a = '{-300, 0, 0}; w = '{300, 0, 0}; drive(1'b1, 1'b1, a, w, 0, 0);  idle(5, 1'b1);
    a = '{-32768, -32768, -32768}; w = '{-32768, -32768, -32768};
    drive(1'b1, 1'b1, a, w, 0, 31);
    a = '{-5, 0, 0};   w = '{1, 0, 0};  drive(1'b1, 1'b1, a, w, 0, 31);  idle(5, 1'b1);

    // back-to-back pixels, each with its own bias and shift
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        a[c] = int'($urandom_range(200)) - 100;
        w[c] = int'($urandom_range(200)) - 100;
      end
      drive(1'b1, 1'b1, a, w, i * 1000 - 1500, i);
    end
    idle(6, 1'b1);

    // reset one edge after a pixel is accepted
    a = '{100, 200, 300}; w = '{7, 8, 9};
    drive(1'b1, 1'b1, a, w, 5, 0);
    idle(1, 1'b0);
    idle(6, 1'b1);

    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < 3; c++) begin
        a[c] = rnd16();
        w[c] = rnd16();
      end
      bias = ($urandom_range(1) == 0) ? int'($urandom) : int'($urandom_range(2000)) - 1000;
      sh   = int'($urandom_range(31));
      drive($urandom_range(3) != 0, $urandom_range(60) != 0, a, w, bias, sh);
    end
    idle(8, 1'b1);

    leftover = exp_map.num();
    check_eq("drain", leftover, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
